// File: rtl/feeder_pkg.sv
// feeder_pkg: shared state encoding and default sizing for the message feeder.
package feeder_pkg;
  localparam int DIGEST_W_DEF = 64;
  localparam int FIFO_DEPTH_DEF = 8;
  typedef enum logic [2:0] {IDLE, START, SEND, EOF, WAIT_H, DONE} state_t;
endpackage

// File: rtl/msg_feeder_if.sv
// msg_feeder_if: host write port, hash-core stream port and digest return grouped as one bundle.
interface msg_feeder_if import feeder_pkg::*; #(parameter int DIGEST_W = DIGEST_W_DEF);
  logic wr_en, wr_last, fifo_full, start, case_rc0, F_dr, F_rtr, End_of_File;
  logic H_ready, digest_valid, digest_ack;
  logic [7:0] wr_data, M_data;
  logic [DIGEST_W-1:0] H_in, digest;
  logic [15:0] msg_bytes;
  modport master(
    output wr_en, wr_data, wr_last, F_rtr, H_ready, H_in, digest_ack,
    input fifo_full, start, case_rc0, F_dr, M_data, End_of_File, digest, digest_valid, msg_bytes
  );
  modport slave(
    input wr_en, wr_data, wr_last, F_rtr, H_ready, H_in, digest_ack,
    output fifo_full, start, case_rc0, F_dr, M_data, End_of_File, digest, digest_valid, msg_bytes
  );
endinterface

// File: rtl/byte_fifo.sv
// byte_fifo: first-word-fall-through FIFO; the head entry is visible on rdata whenever not empty.
module byte_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign rdata = mem[rp];
  always_ff @(posedge clk)
    if (push) mem[wp] <= wdata;
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= push ? wp + 1'b1 : wp;
      rp <= pop ? rp + 1'b1 : rp;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
endmodule

// File: rtl/msg_feeder.sv
// msg_feeder: buffers host message bytes and streams them to a hash core, then captures its digest.
module msg_feeder import feeder_pkg::*; #(
  parameter int DIGEST_W = DIGEST_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input logic clk,
  input logic rst,
  msg_feeder_if.slave bus
);
  state_t state;
  logic push, pop, full, empty, f_dr, dv;
  logic [8:0] head;
  logic [15:0] cnt;
  logic [DIGEST_W-1:0] dig;
  byte_fifo #(.DEPTH(FIFO_DEPTH), .W(9)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop),
    .wdata({bus.wr_last, bus.wr_data}), .rdata(head), .full(full), .empty(empty)
  );
  assign f_dr = state == SEND && !empty;
  assign pop = f_dr && bus.F_rtr;
  // a full FIFO still takes a byte when the head leaves on the same edge
  assign push = bus.wr_en && (!full || pop);
  assign bus.F_dr = f_dr;
  assign bus.M_data = f_dr ? head[7:0] : '0;
  assign bus.start = state == START;
  assign bus.case_rc0 = state == START;
  assign bus.End_of_File = state == EOF;
  assign bus.fifo_full = full;
  assign bus.digest = dig;
  assign bus.digest_valid = dv;
  assign bus.msg_bytes = cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      dig <= '0;
      dv <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= empty ? IDLE : START;
        START: begin
          cnt <= '0;
          state <= SEND;
        end
        SEND: if (pop) begin
          cnt <= cnt == 16'hFFFF ? cnt : cnt + 16'd1;
          state <= head[8] ? EOF : SEND;
        end
        EOF: state <= bus.F_rtr ? WAIT_H : EOF;
        WAIT_H: if (bus.H_ready) begin
          dig <= bus.H_in;
          dv <= 1'b1;
          state <= DONE;
        end
        DONE: if (bus.digest_ack) begin
          dv <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_msg_feeder.sv
// tb_msg_feeder: directed scenarios plus random traffic checked against a queue-based message model.
module tb_msg_feeder;
  localparam int D = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0, n_fail = 0;
  msg_feeder_if #(.DIGEST_W(64)) bus();
  msg_feeder #(.DIGEST_W(64), .FIFO_DEPTH(D)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  // model: queue of accepted {last,byte} entries and a message phase
  localparam int P_IDLE = 0, P_START = 1, P_SEND = 2, P_EOF = 3, P_WAIT = 4, P_DONE = 5;
  logic [8:0] q[$];
  int ph;
  logic [15:0] m_cnt;
  logic [63:0] m_dig;
  logic m_dv;
  logic [63:0] h_val;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    ph = P_IDLE;
    m_cnt = '0;
    m_dig = '0;
    m_dv = 1'b0;
  endtask

  task automatic model_step();
    logic [8:0] hd;
    bit xfer, acc;
    xfer = ph == P_SEND && q.size() > 0 && bus.F_rtr;
    acc = bus.wr_en && (q.size() < D || xfer);
    hd = q.size() > 0 ? q[0] : 9'd0;
    case (ph)
      P_IDLE: if (q.size() > 0) ph = P_START;
      P_START: begin m_cnt = 0; ph = P_SEND; end
      P_SEND: if (xfer) begin
        if (m_cnt != 16'hFFFF) m_cnt++;
        if (hd[8]) ph = P_EOF;
      end
      P_EOF: if (bus.F_rtr) ph = P_WAIT;
      P_WAIT: if (bus.H_ready) begin m_dig = bus.H_in; m_dv = 1; ph = P_DONE; end
      P_DONE: if (bus.digest_ack) begin m_dv = 0; ph = P_IDLE; end
      default: ph = P_IDLE;
    endcase
    if (xfer) void'(q.pop_front());
    if (acc) q.push_back({bus.wr_last, bus.wr_data});
  endtask

  task automatic compare_all();
    bit e_dr;
    e_dr = ph == P_SEND && q.size() > 0;
    chk("start", bus.start, ph == P_START);
    chk("case_rc0", bus.case_rc0, ph == P_START);
    chk("F_dr", bus.F_dr, e_dr);
    chk("M_data", bus.M_data, e_dr ? q[0][7:0] : 8'd0);
    chk("End_of_File", bus.End_of_File, ph == P_EOF);
    chk("fifo_full", bus.fifo_full, q.size() == D);
    chk("digest", bus.digest, m_dig);
    chk("digest_valid", bus.digest_valid, m_dv);
    chk("msg_bytes", bus.msg_bytes, m_cnt);
  endtask

  task automatic step(input logic we, input logic [7:0] wd, input logic wl,
                      input logic rtr, input logic hr, input logic ack);
    bus.wr_en = we; bus.wr_data = wd; bus.wr_last = wl;
    bus.F_rtr = rtr; bus.H_ready = hr; bus.H_in = h_val; bus.digest_ack = ack;
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n, input logic rtr);
    for (int i = 0; i < n; i++) step(0, 8'h00, 0, rtr, 0, 0);
  endtask

  task automatic finish_msg();
    int k = 0;
    while (ph != P_WAIT && k < 40) begin
      step(0, 8'h00, 0, 1, 0, 0);
      k++;
    end
    chk("reach_wait_h", ph == P_WAIT, 1'b1);
    h_val = {$urandom, $urandom};
    step(0, 8'h00, 0, 0, 1, 0);
    step(0, 8'h00, 0, 0, 0, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_start"}, bus.start, 0);
    chk({tag, "_case_rc0"}, bus.case_rc0, 0);
    chk({tag, "_F_dr"}, bus.F_dr, 0);
    chk({tag, "_M_data"}, bus.M_data, 0);
    chk({tag, "_eof"}, bus.End_of_File, 0);
    chk({tag, "_digest"}, bus.digest, 0);
    chk({tag, "_dv"}, bus.digest_valid, 0);
    chk({tag, "_bytes"}, bus.msg_bytes, 0);
    chk({tag, "_full"}, bus.fifo_full, 0);
  endtask

  initial begin
    bus.wr_en = 0; bus.wr_data = 0; bus.wr_last = 0; bus.F_rtr = 0;
    bus.H_ready = 0; bus.H_in = 0; bus.digest_ack = 0;
    h_val = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("rst0");
    rst = 0;
    // basic three-byte message with the core always ready
    step(1, 8'h61, 0, 1, 0, 0);
    step(1, 8'h62, 0, 1, 0, 0);
    step(1, 8'h63, 1, 1, 0, 0);
    idle(4, 1);
    chk("abc_bytes", bus.msg_bytes, 3);
    h_val = 64'h0123_4567_89AB_CDEF;
    step(0, 8'h00, 0, 0, 1, 0);
    chk("abc_digest", bus.digest, 64'h0123_4567_89AB_CDEF);
    idle(3, 0);
    chk("abc_dv_held", bus.digest_valid, 1);
    step(0, 8'h00, 0, 0, 0, 1);
    chk("abc_dv_clr", bus.digest_valid, 0);
    // core stalls with data ready
    step(1, 8'h61, 0, 0, 0, 0);
    step(1, 8'h62, 1, 0, 0, 0);
    idle(1, 0);
    for (int i = 0; i < 5; i++) begin
      chk("stall_M_data", bus.M_data, 8'h61);
      idle(1, 0);
    end
    finish_msg();
    // overfill: ninth byte dropped
    for (int i = 0; i < 9; i++) step(1, 8'h10 + 8'(i), i == 7, 0, 0, 0);
    chk("overfill_full", bus.fifo_full, 1);
    finish_msg();
    // FIFO runs dry mid-message
    step(1, 8'hA0, 0, 1, 0, 0);
    idle(5, 1);
    chk("dry_no_eof", bus.End_of_File, 0);
    step(1, 8'hA1, 1, 1, 0, 0);
    finish_msg();
    // asynchronous reset mid-message
    for (int i = 0; i < 4; i++) step(1, 8'hC0 + 8'(i), i == 3, 0, 0, 0);
    idle(2, 1);
    chk("pre_rst_bytes", bus.msg_bytes, 2);
    #1 rst = 1;
    #1 check_reset_outputs("arst");
    model_reset();
    @(negedge clk);
    rst = 0;
    step(1, 8'h55, 1, 0, 0, 0);
    step(0, 8'h00, 0, 0, 0, 0);
    chk("fresh_start", bus.start, 1);
    finish_msg();
    // random traffic
    for (int i = 0; i < 600; i++) begin
      h_val = {$urandom, $urandom};
      step($urandom_range(0, 1), 8'($urandom), $urandom_range(0, 3) == 0,
           $urandom_range(0, 9) < 7, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
